// File: rtl/addr_burst_mux.sv
// ---------------------------------------------------------------------------
// addr_burst_mux
//
// Selects one of NUM_SRC packed address sources, latches it as a burst base
// and presents an incrementing address sequence to memory over a
// valid/ready handshake. One start request is accepted per burst, and only
// while the block is idle.
//
// Optional feature (compile-time macro ADDR_BURST_SAT_EN):
//   defined   - the address saturates at all-ones: a beat at all-ones is the
//               final beat, whatever beats remain. The remaining beats are
//               dropped silently.
//   undefined - addresses wrap modulo 2**ADDR_W and every requested beat is
//               issued.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   src_addr_i    packed sources, source k at [k*ADDR_W +: ADDR_W]
//   sel_i         source index, sampled when a start is accepted
//   start_i       burst request, honoured only in IDLE
//   burst_len_i   beats minus one, sampled with start_i
//   out_ready_i   memory accepts the current address
//   addr_out_o    current burst address (holds its value in IDLE)
//   addr_valid_o  addr_out_o is valid
//   last_o        current beat is the final one (qualified by addr_valid_o)
//   busy_o        burst in progress
//   err_sel_o     one-cycle pulse after a start with sel_i >= NUM_SRC
//
// State   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no burst; waiting for start_i; addr_out_o holds the last address
// BURST   | address valid; advancing on every accepted beat
// ---------------------------------------------------------------------------
module addr_burst_mux #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr_i,
    input  logic [SEL_W-1:0]          sel_i,
    input  logic                      start_i,
    input  logic [CNT_W-1:0]          burst_len_i,
    input  logic                      out_ready_i,
    output logic [ADDR_W-1:0]         addr_out_o,
    output logic                      addr_valid_o,
    output logic                      last_o,
    output logic                      busy_o,
    output logic                      err_sel_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    rem_q;
    logic                valid_q;
    logic                err_q;

    logic [ADDR_W-1:0]   sel_addr_d;
    logic                sel_ok;
    logic                final_beat;

    // Source mux built as a compare loop so that a non-power-of-two
    // NUM_SRC never produces an out-of-range part-select.
    always_comb begin
        sel_addr_d = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_i == SEL_W'(k)) begin
                sel_addr_d = src_addr_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign sel_ok = (32'(sel_i) < 32'(NUM_SRC));

`ifdef ADDR_BURST_SAT_EN
    // A beat at all-ones ends the burst, so the address never increments
    // past the top and saturation needs no separate clamp.
    assign final_beat = (rem_q == '0) || (addr_q == {ADDR_W{1'b1}});
`else
    assign final_beat = (rem_q == '0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (sel_ok) begin
                            addr_q  <= sel_addr_d;
                            rem_q   <= burst_len_i;
                            valid_q <= 1'b1;
                            state_q <= BURST;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    // valid_q is always set in BURST, so out_ready_i alone
                    // qualifies a transfer here.
                    if (out_ready_i) begin
                        if (final_beat) begin
                            rem_q   <= '0;
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            rem_q  <= rem_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign addr_out_o   = addr_q;
    assign addr_valid_o = valid_q;
    assign last_o       = valid_q && final_beat;
    assign busy_o       = (state_q == BURST);
    assign err_sel_o    = err_q;

endmodule

// File: tb/tb_addr_burst_mux.sv
// ---------------------------------------------------------------------------
// Bench for addr_burst_mux with NUM_SRC=3, so that sel=3 is an illegal
// select. A queue-based reference model expands every accepted burst into
// its full list of addresses; the DUT must present the queue head, and each
// accepted beat pops it.
// ---------------------------------------------------------------------------
module tb_addr_burst_mux;

    localparam int ADDR_W  = 5;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 3;

    logic                      clk;
    logic                      rst;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [SEL_W-1:0]          sel;
    logic                      start;
    logic [CNT_W-1:0]          burst_len;
    logic                      out_ready;
    logic [ADDR_W-1:0]         addr_out;
    logic                      addr_valid;
    logic                      last;
    logic                      busy;
    logic                      err_sel;

    logic [ADDR_W-1:0] src [NUM_SRC];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int exp_q[$];
    int exp_hold = 0;
    int exp_err  = 0;

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            src_addr[k*ADDR_W +: ADDR_W] = src[k];
        end
    end

    addr_burst_mux #(
        .ADDR_W (ADDR_W),
        .NUM_SRC(NUM_SRC),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .src_addr_i  (src_addr),
        .sel_i       (sel),
        .start_i     (start),
        .burst_len_i (burst_len),
        .out_ready_i (out_ready),
        .addr_out_o  (addr_out),
        .addr_valid_o(addr_valid),
        .last_o      (last),
        .busy_o      (busy),
        .err_sel_o   (err_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_edge(input logic r, input logic s, input int sl,
                              input int bl, input logic rdy);
        int a;
        if (r) begin
            exp_q.delete();
            exp_hold = 0;
            exp_err  = 0;
        end else begin
            exp_err = 0;
            if (exp_q.size() > 0) begin
                if (rdy) exp_hold = exp_q.pop_front();
            end else if (s) begin
                if (sl < NUM_SRC) begin
                    for (int i = 0; i <= bl; i++) begin
                        a = (int'(src[sl]) + i) % (1 << ADDR_W);
                        exp_q.push_back(a);
`ifdef ADDR_BURST_SAT_EN
                        if (a == (1 << ADDR_W) - 1) break;
`endif
                    end
                end else begin
                    exp_err = 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        int busy_e;
        busy_e = (exp_q.size() > 0) ? 1 : 0;
        check_val("addr_out",   int'(addr_out), busy_e ? exp_q[0] : exp_hold);
        check_val("addr_valid", int'(addr_valid), busy_e);
        check_val("last",       int'(last), (exp_q.size() == 1) ? 1 : 0);
        check_val("busy",       int'(busy), busy_e);
        check_val("err_sel",    int'(err_sel), exp_err);
    endtask

    task automatic step(input logic r, input logic s, input int sl,
                        input int bl, input logic rdy);
        rst       = r;
        start     = s;
        sel       = SEL_W'(sl);
        burst_len = CNT_W'(bl);
        out_ready = rdy;
        model_edge(r, s, sl, bl, rdy);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = '0; burst_len = '0; out_ready = 1'b0;
        src[0] = 5'd3; src[1] = 5'd22; src[2] = 5'd30;

        // Reset held for two cycles.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Single beat from IR, with a start on the final-beat cycle ignored.
        step(0, 1, 1, 0, 1);
        step(0, 1, 0, 5, 1);
        step(0, 0, 0, 0, 1);

        // PC burst of 4 with backpressure; a mid-burst start is ignored.
        step(0, 1, 0, 3, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 2, 7, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Wrap (or saturate) from 30.
        step(0, 1, 2, 3, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);

        // Illegal select: one-cycle error pulse, no burst.
        step(0, 1, 3, 2, 1);
        step(0, 0, 0, 0, 1);

        // Reset mid-burst, then a clean start from a new base.
        src[2] = 5'd10;
        step(0, 1, 2, 7, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        src[2] = 5'd17;
        step(1, 0, 0, 0, 1);
        step(0, 1, 1, 2, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

        // Randomised traffic, including source changes under a running burst.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) src[$urandom_range(0, NUM_SRC-1)] = ADDR_W'($urandom);
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/addr_burst_mux.md
Name: addr_burst_mux

Overview:
- Parametrised successor to the CPU's 2:1 address mux.
- Selects one of NUM_SRC address sources (PC, IR operand, stack pointer, DMA base, etc.), registers it as a burst base, and emits a sequence of incrementing addresses.
- Uses a valid/ready handshake toward memory.
- Sits between the controller and memory address port; supports multi-word fetch and block transfers.

Parameters:
- ADDR_W, 5, address width in bits.
- NUM_SRC, 4, number of address sources (2..2**SEL_W).
- SEL_W, 2, width of the source select.
- CNT_W, 3, burst-length field width; max burst = 2**CNT_W beats.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- src_addr  in  NUM_SRC*ADDR_W  packed sources; source k occupies bits [k*ADDR_W +: ADDR_W]; source 0 = PC, source 1 = IR.
- sel  in  SEL_W  source index; sampled only when a start is accepted.
- start  in  1  request a burst; accepted only in IDLE.
- burst_len  in  CNT_W  beats minus 1 (0 = single beat); sampled with start.
- out_ready  in  1  memory accepts the current address.
- addr_out  out  ADDR_W  current burst address.
- addr_valid  out  1  addr_out valid.
- last  out  1  current beat is the final beat; qualified by addr_valid.
- busy  out  1  burst in progress.
- err_sel  out  1  one-cycle pulse: start arrived with sel >= NUM_SRC.

Behaviour:
- Reset:
  - Every output is 0; state = IDLE; internal beat counter = 0.
  - Reset mid-burst aborts the burst at the next edge with no final beat.
- States: IDLE, BURST.
- IDLE:
  - If start and sel < NUM_SRC: at the edge, capture base = src_addr[sel], remaining = burst_len, go to BURST.
  - From the next cycle: addr_valid=1, busy=1, addr_out=base. Latency is start -> first valid address = 1 cycle.
  - If start and sel >= NUM_SRC: stay in IDLE; err_sel=1 for exactly one cycle after the edge.
- BURST:
  - A beat transfers on an edge where addr_valid && out_ready.
  - On transfer with remaining != 0: addr_out <= addr_out + 1 (mod 2**ADDR_W), remaining <= remaining - 1.
  - On transfer with remaining == 0: go to IDLE; addr_valid, busy and last clear after the edge.
  - addr_out holds its value while out_ready=0; addr_valid never drops mid-burst.
- last = addr_valid && (remaining == 0).
- start during BURST is ignored; no queuing.
- start on the cycle the final beat transfers is ignored. A new start is accepted no earlier than the cycle after busy falls.
- addr_out holds its last value in IDLE; it does not return to 0 except on reset.
- Wrap-around: addresses increment modulo 2**ADDR_W (31 -> 0 for ADDR_W=5). burst_len is unaffected by the wrap.
- src_addr changes after the accepting edge have no effect on the running burst.

Optional Feature:
- Macro: ADDR_BURST_SAT_EN.
- Defined:
  - The address saturates instead of wrapping.
  - A beat at all-ones asserts last, regardless of remaining. Its transfer ends the burst (early termination).
  - The remaining beats are dropped; no error output.
- Undefined: modular wrap as above; the early-termination logic is absent.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> addr_out=0, addr_valid=0, busy=0, last=0, err_sel=0.
- Single beat: src_addr PC=3, IR=22; sel=1, burst_len=0, start pulse, out_ready=1 -> next cycle addr_out=22, addr_valid=1, last=1; following cycle busy=0, addr_valid=0.
- Burst with backpressure: sel=0 (PC=3), burst_len=3; out_ready toggles 1,0,1,1,1 -> addr_out sequence 3,4,4,5,6; last only on 6; exactly 4 transfers.
- Wrap/saturate: source=30, burst_len=3, out_ready=1:
  - Without macro -> 30,31,0,1, then busy=0.
  - With ADDR_BURST_SAT_EN -> 30,31 with last on 31, then busy=0.
- Illegal select: NUM_SRC=3, sel=3, start -> err_sel high exactly one cycle, busy stays 0. A start during an active burst -> ignored; sequence unchanged.
- Reset mid-burst: burst_len=7 from 10, rst=1 after beat 12 -> next cycle all outputs 0. A start after reset release -> starts cleanly from the new base.
